// File: rtl/pipe_skid_reg.sv
// Inter-stage pipeline register with a 2-entry skid buffer, synchronous flush
// and a saturating stall counter. in_ready depends only on registered state.
module pipe_skid_reg #(
    parameter int DATA_WIDTH    = 32,
    parameter int PAYLOAD_WIDTH = 32,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_pcn,
    input  logic [DATA_WIDTH-1:0]    in_pc,
    input  logic [PAYLOAD_WIDTH-1:0] in_payload,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_pcn,
    output logic [DATA_WIDTH-1:0]    out_pc,
    output logic [PAYLOAD_WIDTH-1:0] out_payload,
    output logic [CNT_WIDTH-1:0]     stall_cnt
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both 1; valid never waits on ready, and in_ready never looks at out_ready.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_WIDTH-1:0]    main_pc, main_pcn, skid_pc, skid_pcn;
    logic [PAYLOAD_WIDTH-1:0] main_payload, skid_payload;

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (in_fire) state_nxt = BUSY;
            BUSY: begin
                if (in_fire && !out_fire) begin
                    state_nxt = FULL;
                end else if (!in_fire && out_fire) begin
                    state_nxt = EMPTY;
                end
            end
            FULL:    if (out_fire) state_nxt = BUSY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        in_ready  = (state != FULL);
        out_valid = (state != EMPTY);
    end

    // Entries are zeroed whenever they empty so outputs read 0 during bubbles.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            main_pc      <= '0;
            main_pcn     <= '0;
            main_payload <= '0;
            skid_pc      <= '0;
            skid_pcn     <= '0;
            skid_payload <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_pc      <= in_pc;
                        main_pcn     <= in_pcn;
                        main_payload <= in_payload;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_pc      <= in_pc;
                        main_pcn     <= in_pcn;
                        main_payload <= in_payload;
                    end else if (in_fire) begin
                        skid_pc      <= in_pc;
                        skid_pcn     <= in_pcn;
                        skid_payload <= in_payload;
                    end else if (out_fire) begin
                        main_pc      <= '0;
                        main_pcn     <= '0;
                        main_payload <= '0;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_pc      <= skid_pc;
                        main_pcn     <= skid_pcn;
                        main_payload <= skid_payload;
                        skid_pc      <= '0;
                        skid_pcn     <= '0;
                        skid_payload <= '0;
                    end
                end
                default: begin
                    main_pc      <= '0;
                    main_pcn     <= '0;
                    main_payload <= '0;
                    skid_pc      <= '0;
                    skid_pcn     <= '0;
                    skid_payload <= '0;
                end
            endcase
        end
    end

    assign out_pc      = main_pc;
    assign out_pcn     = main_pcn;
    assign out_payload = main_payload;

    // Flush does not clear the counter; a flush cycle that stalls still counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_WIDTH{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: a queue-based reference model of the two-entry
// stage, directed scenario tasks and a randomized stream.
module tb_pipe_skid_reg;

    localparam int DW = 32;
    localparam int PW = 32;
    localparam int EW = 2 * DW + PW;

    logic          clk = 0;
    logic          rst = 0;
    logic          flush = 0;
    logic          in_valid = 0;
    logic          out_ready = 0;
    logic [DW-1:0] in_pc = '0, in_pcn = '0;
    logic [PW-1:0] in_payload = '0;

    logic          in_ready, out_valid, in_ready3, out_valid3;
    logic [DW-1:0] out_pc, out_pcn, out_pc3, out_pcn3;
    logic [PW-1:0] out_payload, out_payload3;
    logic [15:0]   stall_cnt;
    logic [2:0]    stall_cnt3;

    int errors = 0;
    int checks = 0;

    // Reference model: queued entries {pc, pcn, payload} and raw stall count
    logic [EW-1:0] exp_q[$];
    int unsigned   m_cnt = 0;

    always #5 clk = ~clk;

    pipe_skid_reg dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pcn(in_pcn), .in_pc(in_pc), .in_payload(in_payload),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pcn(out_pcn), .out_pc(out_pc), .out_payload(out_payload),
        .stall_cnt(stall_cnt)
    );

    pipe_skid_reg #(.CNT_WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready3),
        .in_pcn(in_pcn), .in_pc(in_pc), .in_payload(in_payload),
        .out_valid(out_valid3), .out_ready(out_ready),
        .out_pcn(out_pcn3), .out_pc(out_pc3), .out_payload(out_payload3),
        .stall_cnt(stall_cnt3)
    );

    function automatic logic [EW-1:0] exp_front();
        if (exp_q.size() > 0) return exp_q[0];
        return '0;
    endfunction

    function automatic logic [15:0] exp_cnt16();
        return (m_cnt > 65535) ? 16'hFFFF : m_cnt[15:0];
    endfunction

    function automatic logic [2:0] exp_cnt3();
        return (m_cnt > 7) ? 3'd7 : m_cnt[2:0];
    endfunction

    // One clock edge: model advances with the inputs seen at that edge.
    task automatic tick();
        bit ov, ir, in_f, out_f;
        ov    = exp_q.size() > 0;
        ir    = exp_q.size() < 2;
        in_f  = in_valid && ir;
        out_f = ov && out_ready;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            m_cnt = 0;
        end else begin
            if (ov && !out_ready) m_cnt++;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (out_f) void'(exp_q.pop_front());
                if (in_f) exp_q.push_back({in_pc, in_pcn, in_payload});
            end
        end
        #1;
    endtask

    task automatic offer(input logic [DW-1:0] pc);
        in_valid   = 1;
        in_pc      = pc;
        in_pcn     = pc + 4;
        in_payload = $urandom;
    endtask

    task automatic test_reset();
        rst = 1; flush = 0; out_ready = 0;
        offer(32'h100);
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        checks++;
        if ({out_pc, out_pcn, out_payload} !== '0) begin
            errors++;
            $display("FAIL reset_data: pc=%h pcn=%h pl=%h want 0", out_pc, out_pcn, out_payload);
        end
        checks++;
        if (stall_cnt !== 16'd0 || stall_cnt3 !== 3'd0) begin
            errors++;
            $display("FAIL reset_cnt: %0d/%0d want 0", stall_cnt, stall_cnt3);
        end
        rst = 0; in_valid = 0;
    endtask

    task automatic test_streaming();
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            offer(32'(4 * i));
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_pcn !== 32'(4 * i + 4)) begin
                errors++;
                $display("FAIL stream_%0d: v=%b pc=%h pcn=%h want pc=%h", i, out_valid, out_pc, out_pcn, 4 * i);
            end
            checks++;
            if (in_ready !== 1'b1 || stall_cnt !== 16'd0) begin
                errors++;
                $display("FAIL stream_rdy_%0d: in_ready=%b cnt=%0d want 1/0", i, in_ready, stall_cnt);
            end
        end
        in_valid = 0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_pc !== '0) begin
            errors++;
            $display("FAIL stream_drain: v=%b pc=%h want 0/0", out_valid, out_pc);
        end
    endtask

    task automatic test_backpressure();
        int unsigned c0;
        c0 = m_cnt;
        out_ready = 0;
        offer(32'h10); tick();
        checks++;
        if (out_pc !== 32'h10 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_first: pc=%h rdy=%b want 10/1", out_pc, in_ready);
        end
        offer(32'h14); tick();
        checks++;
        if (in_ready !== 1'b0 || out_pc !== 32'h10 || stall_cnt !== 16'(c0 + 1)) begin
            errors++;
            $display("FAIL bp_full: rdy=%b pc=%h cnt=%0d want 0/10/%0d", in_ready, out_pc, stall_cnt, c0 + 1);
        end
        offer(32'h18); tick();
        checks++;
        if (in_ready !== 1'b0 || out_pc !== 32'h10 || stall_cnt !== 16'(c0 + 2)) begin
            errors++;
            $display("FAIL bp_hold: rdy=%b pc=%h cnt=%0d want 0/10/%0d", in_ready, out_pc, stall_cnt, c0 + 2);
        end
        in_valid = 0; out_ready = 1;
        tick();
        checks++;
        if (out_pc !== 32'h14 || out_pcn !== 32'h18 || in_ready !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain1: pc=%h pcn=%h rdy=%b v=%b want 14/18/1/1", out_pc, out_pcn, in_ready, out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || stall_cnt !== 16'(c0 + 2)) begin
            errors++;
            $display("FAIL bp_drain2: v=%b cnt=%0d want 0/%0d (0x18 must not appear)", out_valid, stall_cnt, c0 + 2);
        end
    endtask

    task automatic test_flush();
        out_ready = 0;
        offer(32'h30); tick();
        offer(32'h34); tick();
        offer(32'h40); flush = 1;
        tick();
        flush = 0; in_valid = 0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || {out_pc, out_pcn, out_payload} !== '0) begin
            errors++;
            $display("FAIL flush: v=%b rdy=%b pc=%h pcn=%h pl=%h want 0/1/0", out_valid, in_ready, out_pc, out_pcn, out_payload);
        end
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_leak_%0d: v=%b pc=%h want v=0", i, out_valid, out_pc);
            end
        end
    endtask

    task automatic test_saturation();
        rst = 1; tick(); rst = 0;
        out_ready = 0;
        offer(32'h50); tick();
        in_valid = 0;
        repeat (10) tick();
        checks++;
        if (stall_cnt3 !== 3'd7 || stall_cnt !== 16'd10) begin
            errors++;
            $display("FAIL sat: cnt3=%0d cnt16=%0d want 7/10", stall_cnt3, stall_cnt);
        end
        flush = 1; tick(); flush = 0;
        checks++;
        if (stall_cnt3 !== 3'd7 || stall_cnt !== 16'd11 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sat_flush: cnt3=%0d cnt16=%0d v=%b want 7/11/0", stall_cnt3, stall_cnt, out_valid);
        end
        rst = 1; tick(); rst = 0;
        checks++;
        if (stall_cnt3 !== 3'd0 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL sat_rst: cnt3=%0d cnt16=%0d want 0/0", stall_cnt3, stall_cnt);
        end
    endtask

    task automatic test_simultaneous();
        out_ready = 0;
        offer(32'h20); tick();
        offer(32'h24); out_ready = 1;
        tick();
        checks++;
        if (out_pc !== 32'h24 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL simul: pc=%h v=%b rdy=%b want 24/1/1", out_pc, out_valid, in_ready);
        end
        offer(32'h28); rst = 1;
        tick();
        rst = 0; in_valid = 0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || {out_pc, out_pcn, out_payload} !== '0) begin
            errors++;
            $display("FAIL simul_rst: v=%b rdy=%b pc=%h want 0/1/0", out_valid, in_ready, out_pc);
        end
    endtask

    task automatic test_random();
        logic [EW-1:0] e;
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_pc      = $urandom;
            in_pcn     = $urandom;
            in_payload = $urandom;
            out_ready  = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 24) == 0);
            rst        = ($urandom_range(0, 99) == 0);
            tick();
            e = exp_front();
            checks++;
            if (out_valid !== (exp_q.size() > 0) || in_ready !== (exp_q.size() < 2) ||
                {out_pc, out_pcn, out_payload} !== e) begin
                errors++;
                $display("FAIL rand_%0d: v=%b rdy=%b data=%h want v=%b rdy=%b data=%h", i, out_valid,
                         in_ready, {out_pc, out_pcn, out_payload}, exp_q.size() > 0, exp_q.size() < 2, e);
            end
            checks++;
            if (stall_cnt !== exp_cnt16() || stall_cnt3 !== exp_cnt3()) begin
                errors++;
                $display("FAIL rand_cnt_%0d: cnt16=%0d cnt3=%0d want %0d/%0d", i, stall_cnt, stall_cnt3,
                         exp_cnt16(), exp_cnt3());
            end
        end
        rst = 0; flush = 0; in_valid = 0;
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_saturation();
        test_simultaneous();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
